// File: rtl/enc_pkg.sv
// Shared definitions for the one-hot serial encoder: default widths, FSM
// state encoding and the one-hot to binary index helper.
package enc_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int IDX_W_DEF = $clog2(WIDTH_DEF);
  // Widest vector the index helper can encode.
  localparam int MAX_WIDTH = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // OR-encoder: returns the bit position of a one-hot vector (0 for all-zero).
  // Result is meaningless for vectors with more than one bit set.
  function automatic int unsigned onehot_to_idx(input logic [MAX_WIDTH-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
      if (onehot[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_idx_find.sv
// Combinational priority finder: index of the lowest (or highest) set bit of
// vec, plus a flag telling whether vec has exactly one bit set.
module prio_idx_find
  import enc_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             single
);

  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] iso;
  logic [IDX_W-1:0] pos;

  // Highest-first is handled by bit-reversing the input, isolating its lowest
  // set bit, and mirroring the index back (~pos == WIDTH-1-pos for 2^n widths).
  always_comb begin
    src = vec;
    if (!LSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) src[i] = vec[WIDTH-1-i];
    end
    iso    = src & (~src + WIDTH'(1));
    pos    = IDX_W'(onehot_to_idx(MAX_WIDTH'(iso)));
    idx    = LSB_FIRST ? pos : ~pos;
    single = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
  end

endmodule

// File: rtl/onehot_serial_encoder.sv
// Serialises a request/flag vector into one binary index per set bit.
// Vector in via valid/ready, indices out via valid/ready; all outputs are
// decoded from registers only.
module onehot_serial_encoder
  import enc_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int IDX_W     = $clog2(WIDTH),
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             zero_err,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             zero_err_q, zero_err_d;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_single;
  logic             scan_valid;

  prio_idx_find #(
    .WIDTH    (WIDTH),
    .IDX_W    (IDX_W),
    .LSB_FIRST(LSB_FIRST)
  ) u_find (
    .vec   (pending_q),
    .idx   (sel_idx),
    .single(sel_single)
  );

  // A zero-pending SCAN is unreachable; it never presents a beat.
  assign scan_valid = (state_q == SCAN) && (pending_q != '0);

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SCAN);
  assign out_valid = scan_valid;
  // Index forced to 0 when idle so a highest-first finder does not show WIDTH-1.
  assign out_idx   = scan_valid ? sel_idx : '0;
  assign out_last  = scan_valid & sel_single;
  assign zero_err  = zero_err_q;

  // Next-state logic: accept a vector in IDLE, retire one set bit per
  // output handshake in SCAN.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    pending_d  = pending_q;
    zero_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_vec != '0) begin
            pending_d = in_vec;
            state_d   = SCAN;
          end else begin
            zero_err_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (pending_q == '0) begin
          state_d = IDLE;
        end else if (out_ready) begin
          pending_d[sel_idx] = 1'b0;
          if (sel_single) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pending vector and error pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge here, so rst_n is not in the sensitivity list.
    if (!rst_n) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      zero_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state_q    <= state_d;
      pending_q  <= pending_d;
      zero_err_q <= zero_err_d;
    end
  end

endmodule

// File: tb/tb_onehot_serial_encoder.sv
// Self-checking bench for onehot_serial_encoder: directed scenarios plus a
// randomised run checked by a queue-based scoreboard fed from a bit-scan model.
module tb_onehot_serial_encoder;
  import enc_pkg::*;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready, out_last, zero_err, busy;
  logic [7:0] in_vec;
  logic [2:0] out_idx;

  logic       in_valid_m, in_ready_m, out_valid_m, out_ready_m, out_last_m, zero_err_m, busy_m;
  logic [7:0] in_vec_m;
  logic [2:0] out_idx_m;

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic       stall_prev = 1'b0;
  logic [2:0] prev_idx   = '0;
  logic       prev_last  = 1'b0;

  onehot_serial_encoder #(.WIDTH(8), .IDX_W(3), .LSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_last(out_last),
    .zero_err(zero_err), .busy(busy)
  );

  onehot_serial_encoder #(.WIDTH(8), .IDX_W(3), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_m), .in_ready(in_ready_m), .in_vec(in_vec_m),
    .out_valid(out_valid_m), .out_ready(out_ready_m), .out_idx(out_idx_m), .out_last(out_last_m),
    .zero_err(zero_err_m), .busy(busy_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-hot of the lowest (lsb=1) or highest (lsb=0) set bit, found by scanning.
  function automatic logic [7:0] pick(input logic [7:0] v, input bit lsb);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (lsb && v[i] && p == '0) p[i] = 1'b1;
      if (!lsb && v[7-i] && p == '0) p[7-i] = 1'b1;
    end
    return p;
  endfunction

  function automatic logic [2:0] pos_of(input logic [7:0] p);
    return 3'(onehot_to_idx(32'(p)));
  endfunction

  // Reference model for the lowest-first instance: queue one beat per set bit.
  function automatic void push_model(input logic [7:0] v);
    logic [7:0] rem, p;
    exp_t e;
    rem = v;
    while (rem != '0) begin
      p      = pick(rem, 1'b1);
      e.idx  = pos_of(p);
      e.last = (rem == p);
      exp_q.push_back(e);
      rem = rem & ~p;
    end
  endfunction

  // Scoreboard monitor: pops on every output handshake, checks stall stability
  // and that nothing is accepted while busy.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got idx=%0d last=%0b, required no beat", out_idx, out_last);
        end else begin
          mon_e = exp_q.pop_front();
          if ({out_idx, out_last} !== {mon_e.idx, mon_e.last}) begin
            bad++;
            $display("FAIL sb_beat: got idx=%0d last=%0b, required idx=%0d last=%0b",
                     out_idx, out_last, mon_e.idx, mon_e.last);
          end
        end
      end
      if (stall_prev) begin
        total++;
        if (out_valid !== 1'b1 || out_idx !== prev_idx || out_last !== prev_last) begin
          bad++;
          $display("FAIL stall_hold: got v=%0b idx=%0d last=%0b, required v=1 idx=%0d last=%0b",
                   out_valid, out_idx, out_last, prev_idx, prev_last);
        end
      end
      if (in_valid && in_ready) begin
        total++;
        if (busy !== 1'b0) begin
          bad++;
          $display("FAIL accept_busy: got busy=%0b at accept, required 0", busy);
        end
      end
      stall_prev <= out_valid && !out_ready;
      prev_idx   <= out_idx;
      prev_last  <= out_last;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  // Offer v until accepted (bounded), queue its expected beats, drop valid.
  task automatic send(input logic [7:0] v);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_vec   = v;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: in_ready stayed 0 for vec=%h, required 1", v);
    end else begin
      push_model(v);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
    in_valid_m = 1'b0; in_vec_m = '0; out_ready_m = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, out_idx, out_last, busy, zero_err} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_lsb: got rdy=%0b v=%0b idx=%0d last=%0b busy=%0b zerr=%0b, required 1 0 0 0 0 0",
               in_ready, out_valid, out_idx, out_last, busy, zero_err);
    end
    total++;
    if ({in_ready_m, out_valid_m, out_idx_m, out_last_m, busy_m, zero_err_m} !== {1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_msb: got rdy=%0b v=%0b idx=%0d last=%0b busy=%0b zerr=%0b, required 1 0 0 0 0 0",
               in_ready_m, out_valid_m, out_idx_m, out_last_m, busy_m, zero_err_m);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_bit();
    out_ready = 1'b1;
    send(8'b0001_0000);
    @(negedge clk);
    total++;
    if ({out_valid, out_idx, out_last, busy} !== {1'b1, 3'd4, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL single_beat: got v=%0b idx=%0d last=%0b busy=%0b, required 1 4 1 1",
               out_valid, out_idx, out_last, busy);
    end
    @(negedge clk);
    total++;
    if ({in_ready, busy, out_valid} !== {1'b1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL single_done: got rdy=%0b busy=%0b v=%0b, required 1 0 0", in_ready, busy, out_valid);
    end
  endtask

  task automatic test_multi_lsb();
    logic [7:0] rem, p;
    rem = 8'b1010_0110;
    out_ready = 1'b1;
    send(rem);
    while (rem != '0) begin
      p = pick(rem, 1'b1);
      @(negedge clk);
      total++;
      if ({out_valid, out_idx, out_last} !== {1'b1, pos_of(p), rem == p}) begin
        bad++;
        $display("FAIL multi_lsb: got v=%0b idx=%0d last=%0b, required 1 %0d %0b",
                 out_valid, out_idx, out_last, pos_of(p), rem == p);
      end
      rem = rem & ~p;
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL multi_lsb_ready: got %0b, required 1", in_ready);
    end
  endtask

  task automatic test_multi_msb();
    logic [7:0] rem, p;
    rem = 8'b1010_0110;
    out_ready_m = 1'b1;
    @(posedge clk); #1;
    in_valid_m = 1'b1;
    in_vec_m   = rem;
    @(negedge clk);
    total++;
    if (in_ready_m !== 1'b1) begin
      bad++;
      $display("FAIL msb_accept: got in_ready=%0b, required 1", in_ready_m);
    end
    @(posedge clk); #1;
    in_valid_m = 1'b0;
    while (rem != '0) begin
      p = pick(rem, 1'b0);
      @(negedge clk);
      total++;
      if ({out_valid_m, out_idx_m, out_last_m} !== {1'b1, pos_of(p), rem == p}) begin
        bad++;
        $display("FAIL multi_msb: got v=%0b idx=%0d last=%0b, required 1 %0d %0b",
                 out_valid_m, out_idx_m, out_last_m, pos_of(p), rem == p);
      end
      rem = rem & ~p;
    end
    @(negedge clk);
    total++;
    if ({in_ready_m, busy_m} !== {1'b1, 1'b0}) begin
      bad++;
      $display("FAIL msb_done: got rdy=%0b busy=%0b, required 1 0", in_ready_m, busy_m);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(8'b1000_0001);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_idx, out_last} !== {1'b1, 3'd0, 1'b0}) begin
        bad++;
        $display("FAIL bp_stall%0d: got v=%0b idx=%0d last=%0b, required 1 0 0",
                 i, out_valid, out_idx, out_last);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({out_valid, out_idx, out_last} !== {1'b1, 3'd0, 1'b0}) begin
      bad++;
      $display("FAIL bp_first: got v=%0b idx=%0d last=%0b, required 1 0 0", out_valid, out_idx, out_last);
    end
    @(negedge clk);
    total++;
    if ({out_valid, out_idx, out_last} !== {1'b1, 3'd7, 1'b1}) begin
      bad++;
      $display("FAIL bp_second: got v=%0b idx=%0d last=%0b, required 1 7 1", out_valid, out_idx, out_last);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_end: got out_valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_zero();
    out_ready = 1'b1;
    send(8'h00);
    @(negedge clk);
    total++;
    if ({zero_err, out_valid, in_ready} !== {1'b1, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL zero_pulse: got zerr=%0b v=%0b rdy=%0b, required 1 0 1", zero_err, out_valid, in_ready);
    end
    @(negedge clk);
    total++;
    if ({zero_err, out_valid, in_ready} !== {1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL zero_after: got zerr=%0b v=%0b rdy=%0b, required 0 0 1", zero_err, out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_scan();
    out_ready = 1'b1;
    send(8'hFF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, out_idx} !== {1'b1, 3'(i)}) begin
        bad++;
        $display("FAIL rst_mid_pre%0d: got v=%0b idx=%0d, required 1 %0d", i, out_valid, out_idx, i);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    total++;
    if ({out_valid, in_ready, busy} !== {1'b0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL rst_mid_after: got v=%0b rdy=%0b busy=%0b, required 0 1 0", out_valid, in_ready, busy);
    end
    send(8'b0000_1000);
    @(negedge clk);
    total++;
    if ({out_valid, out_idx, out_last} !== {1'b1, 3'd3, 1'b1}) begin
      bad++;
      $display("FAIL rst_mid_next: got v=%0b idx=%0d last=%0b, required 1 3 1", out_valid, out_idx, out_last);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_end: got out_valid=%0b, required 0", out_valid);
    end
  endtask

  task automatic test_random();
    bit drop;
    int n;
    drop = 1'b0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (drop) begin
        in_valid = 1'b0;
        drop     = 1'b0;
      end
      if (!in_valid && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b1;
        case ($urandom_range(0, 5))
          0:       in_vec = 8'h00;
          1:       in_vec = 8'h01 << $urandom_range(0, 7);
          2:       in_vec = 8'hFF;
          default: in_vec = 8'($urandom);
        endcase
      end else if (in_valid && !in_ready) begin
        in_vec = 8'($urandom);
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        push_model(in_vec);
        drop = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL random_drain: got %0d beats outstanding, out_valid=%0b, required 0 and 0",
               exp_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_multi_lsb();
    test_multi_msb();
    test_backpressure();
    test_zero();
    test_reset_mid_scan();
    test_random();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/onehot_serial_encoder.md
Name: onehot_serial_encoder

Overview:
- Encoder counterpart to the team's 3-to-8 one-hot decoder.
- Accepts an 8-bit request or flag vector through a valid/ready handshake, then emits one 3-bit index per set bit, with its own valid/ready handshake.
- Emission order is lowest bit first by default.
- Sits between event or interrupt flag sources and index-driven consumers, such as a decoder driving per-line enables.

Parameters:
- WIDTH, 8, input vector width; must be a power of two and at least 2.
- IDX_W, $clog2(WIDTH) = 3, index output width.
- LSB_FIRST, 1, 1 = emit lowest set bit first; 0 = emit highest set bit first.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  upstream has a vector.
- in_ready  out  1  block can accept a vector.
- in_vec  in  WIDTH  request vector; sampled only on in_valid && in_ready.
- out_valid  out  1  out_idx/out_last valid.
- out_ready  in  1  downstream accepts the current index.
- out_idx  out  IDX_W  binary index of the selected set bit.
- out_last  out  1  current index is the final set bit of this vector.
- zero_err  out  1  one-cycle pulse when an all-zero vector was accepted.
- busy  out  1  high while in SCAN.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, pending=0, zero_err=0.
  - This gives in_ready=1, out_valid=0, out_idx=0, out_last=0, busy=0.
  - Reset has priority over every other event, including mid-SCAN: pending indices are discarded and out_valid drops at that edge.
- Outputs are derived only from registers (state, pending, zero_err). There is no combinational path from in_* or out_ready to any output.
- States:
  - IDLE: in_ready=1, out_valid=0, busy=0.
    - On in_valid && in_vec!=0: pending<=in_vec, go to SCAN.
    - On in_valid && in_vec==0: zero_err<=1 for exactly one cycle, stay in IDLE. Nothing is emitted.
  - SCAN: in_ready=0, out_valid=1, busy=1.
    - out_idx = position of the lowest set bit of pending (highest if LSB_FIRST=0).
    - out_last = (pending has exactly one bit set).
    - On out_ready: clear that bit in pending.
    - If out_last, go to IDLE (pending becomes 0); otherwise stay in SCAN and present the next index on the following cycle.
- Latency:
  - A vector accepted at edge N gives out_valid=1 from cycle N+1.
  - Each index occupies at least 1 cycle. A vector with k set bits and out_ready held high occupies k cycles.
  - in_ready returns to 1 the cycle after the last handshake.
- Throughput: no overlap; the next vector cannot be accepted on the same edge as the final index handshake (in_ready=0 in SCAN).
- Backpressure: while out_valid && !out_ready, out_idx and out_last are held stable and pending is unchanged.
- The index is always a valid bit position (0..WIDTH-1). Pending is never zero in SCAN; an unreachable zero-pending SCAN returns to IDLE with out_valid=0.
- in_vec is ignored when in_ready=0.
- Single-bit vector: one beat with out_last=1, so the block behaves as a registered 8-to-3 encoder.
- All-ones vector: 8 beats, indices 0..7 (or 7..0), with out_last on the final beat only.

Decomposition:
- Shared package `enc_pkg` holds:
  - the WIDTH/IDX_W defaults;
  - the state enum {IDLE, SCAN};
  - a function `onehot_to_idx` that is also reusable by verification for the reference model.
- One sub-module, `prio_idx_find`, is natural. It is purely combinational:
  - parameters WIDTH and LSB_FIRST;
  - input vec;
  - outputs idx and `single` (exactly one bit set).
- The top level holds the FSM, the pending register and the handshakes.

Test Plan:
1. Reset, then in_vec=8'b0001_0000 with in_valid=1, out_ready=1:
   - accepted at edge 1;
   - cycle 2: out_valid=1, out_idx=4, out_last=1;
   - cycle 3: in_ready=1, busy=0.
2. in_vec=8'b1010_0110 with out_ready=1:
   - indices 1,2,5,7 on consecutive cycles;
   - out_last only with 7.
   - Repeat with LSB_FIRST=0: 7,5,2,1.
3. Backpressure on in_vec=8'b1000_0001:
   - hold out_ready=0 for 3 cycles; out_idx stays 0 and out_last=0;
   - release: index 0, then index 7 with out_last=1.
4. in_vec=8'h00 accepted:
   - zero_err=1 for exactly one cycle;
   - out_valid never rises; in_ready stays 1.
5. Reset mid-SCAN:
   - load 8'hFF, take 3 indices (0,1,2), assert rst_n=0 for one edge;
   - next cycle out_valid=0, in_ready=1;
   - the following vector 8'b0000_1000 yields a single index 3.
6. Random vectors against the `enc_pkg` model, with random out_ready and in_valid:
   - index sequence matches the model;
   - no vector accepted while busy;
   - out_idx stable under stall.
